// File: rtl/shift_deserializer.sv
// shift_deserializer: serial-to-parallel word receiver with valid/ready output, bit-gap timeout, overrun flag, optional parity (PARITY_EN)
module shift_deserializer #(
  parameter int WIDTH = 5,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             msb_first,
  input  logic             bit_valid,
  input  logic             bit_in,
  output logic             word_valid,
  input  logic             word_ready,
  output logic [WIDTH-1:0] word_out,
  output logic             busy,
  output logic             overrun,
  output logic             timeout_err,
  output logic             parity_err
);
`ifdef PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH + 2);
  localparam int GW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [GW-1:0] gap_q, gap_d;
  logic msb_q, msb_d, ovr_q, ovr_d, tmo_q, tmo_d, par_q, par_d, perr_q, perr_d;
  always_comb begin
    state_d = state_q;
    sreg_d = sreg_q;
    cnt_d = cnt_q;
    gap_d = gap_q;
    msb_d = msb_q;
    ovr_d = ovr_q;
    tmo_d = 1'b0;
    par_d = par_q;
    perr_d = perr_q;
    if (state_q != HOLD && start) begin
      state_d = COLLECT;
      sreg_d = '0;
      cnt_d = '0;
      gap_d = '0;
      msb_d = msb_first;
      ovr_d = 1'b0;
      par_d = 1'b0;
      perr_d = 1'b0;
    end else if (state_q == COLLECT && bit_valid) begin
      gap_d = '0;
      cnt_d = cnt_q + 1'b1;
      if (int'(cnt_q) < WIDTH) begin
        sreg_d = msb_q ? {sreg_q[WIDTH-2:0], bit_in} : {bit_in, sreg_q[WIDTH-1:1]};
        par_d = par_q ^ bit_in;
      end
      if (int'(cnt_q) == FRAME - 1) begin
        state_d = HOLD;
        cnt_d = '0;
        perr_d = (FRAME > WIDTH) ? par_q ^ bit_in : 1'b0;
      end
    end else if (state_q == COLLECT) begin
      gap_d = gap_q + 1'b1;
      if (int'(gap_q) == TIMEOUT - 1) begin
        state_d = IDLE;
        sreg_d = '0;
        cnt_d = '0;
        gap_d = '0;
        tmo_d = 1'b1;
      end
    end else if (state_q == HOLD) begin
      ovr_d = ovr_q | bit_valid;
      state_d = word_ready ? IDLE : HOLD;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sreg_q <= '0;
      cnt_q <= '0;
      gap_q <= '0;
      msb_q <= 1'b0;
      ovr_q <= 1'b0;
      tmo_q <= 1'b0;
      par_q <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q <= sreg_d;
      cnt_q <= cnt_d;
      gap_q <= gap_d;
      msb_q <= msb_d;
      ovr_q <= ovr_d;
      tmo_q <= tmo_d;
      par_q <= par_d;
      perr_q <= perr_d;
    end
  end
  assign word_out = sreg_q;
  assign word_valid = state_q == HOLD;
  assign busy = state_q != IDLE;
  assign overrun = ovr_q;
  assign timeout_err = tmo_q;
  assign parity_err = perr_q;
endmodule

// File: tb/tb_shift_deserializer.sv
// tb_shift_deserializer: randomized and directed checks of shift_deserializer against a positional reference model
module tb_shift_deserializer;
  localparam int WIDTH = 5;
  localparam int TIMEOUT = 15;
`ifdef PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  logic clk = 0, rst_n = 1, start = 0, msb_first = 0, bit_valid = 0, bit_in = 0, word_ready = 0;
  logic word_valid, busy, overrun, timeout_err, parity_err;
  logic [WIDTH-1:0] word_out;
  int n_cmp = 0, n_bad = 0;
  shift_deserializer #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .msb_first(msb_first),
    .bit_valid(bit_valid), .bit_in(bit_in), .word_valid(word_valid),
    .word_ready(word_ready), .word_out(word_out), .busy(busy),
    .overrun(overrun), .timeout_err(timeout_err), .parity_err(parity_err)
  );
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic do_start(input logic msb);
    start = 1;
    msb_first = msb;
    cyc();
    start = 0;
    msb_first = ~msb;
  endtask
  task automatic send(input logic b, input int gap);
    repeat (gap) cyc();
    bit_valid = 1;
    bit_in = b;
    cyc();
    bit_valid = 0;
    bit_in = 1'($urandom);
  endtask
  // f[i] is the i-th bit on the wire; data bit i lands at a fixed word position
  function automatic logic [WIDTH-1:0] model_word(input logic [FRAME-1:0] f, input logic msb);
    logic [WIDTH-1:0] w = '0;
    for (int i = 0; i < WIDTH; i++) w[msb ? WIDTH-1-i : i] = f[i];
    return w;
  endfunction
  function automatic logic model_par(input logic [FRAME-1:0] f);
    return (FRAME > WIDTH) ? ^f : 1'b0;
  endfunction
  // builds a wire sequence from a left-to-right literal, appending a good or bad parity bit
  function automatic logic [FRAME-1:0] seq(input logic [WIDTH-1:0] s, input logic good);
    logic [FRAME-1:0] f = '0;
    for (int i = 0; i < WIDTH; i++) f[i] = s[WIDTH-1-i];
    f[FRAME-1] = (FRAME > WIDTH) ? (^s ^ ~good) : s[0];
    return f;
  endfunction
  task automatic send_frame(input logic [FRAME-1:0] f, input logic msb, input int gmax);
    do_start(msb);
    for (int i = 0; i < FRAME; i++) send(f[i], $urandom_range(0, gmax));
  endtask
  task automatic test_reset();
    #2 rst_n = 0;
    #1;
    n_cmp++;
    if ({word_valid, busy, overrun, timeout_err, parity_err, word_out} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b required 0", {word_valid, busy, overrun, timeout_err, parity_err, word_out});
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    cyc();
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_idle_busy: got %b required 0", busy); end
  endtask
  task automatic test_msb_first();
    logic [FRAME-1:0] f = seq(5'b10011, 1'b1);
    word_ready = 1;
    start = 1; msb_first = 1; bit_valid = 1; bit_in = 1;
    cyc();
    start = 0; msb_first = 0; bit_valid = 0;
    n_cmp++;
    if (busy !== 1'b1 || word_out !== '0) begin n_bad++; $display("FAIL msb_start: busy %b word %b required 1/00000", busy, word_out); end
    for (int i = 0; i < FRAME; i++) send(f[i], 0);
    n_cmp++;
    if (word_valid !== 1'b1 || word_out !== 5'b10011) begin n_bad++; $display("FAIL msb_word: valid %b word %b required 1/10011", word_valid, word_out); end
    cyc();
    n_cmp++;
    if (word_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL msb_one_cycle: valid %b busy %b required 0/0", word_valid, busy); end
    word_ready = 0;
  endtask
  task automatic test_lsb_gaps();
    logic [FRAME-1:0] f = seq(5'b10011, 1'b1);
    logic tmo_seen = 0;
    do_start(0);
    for (int i = 0; i < FRAME; i++) begin
      repeat (3) begin cyc(); tmo_seen |= timeout_err; end
      bit_valid = 1; bit_in = f[i];
      cyc();
      bit_valid = 0;
    end
    n_cmp++;
    if (tmo_seen !== 1'b0) begin n_bad++; $display("FAIL lsb_no_timeout: got %b required 0", tmo_seen); end
    n_cmp++;
    if (word_valid !== 1'b1 || word_out !== 5'b11001) begin n_bad++; $display("FAIL lsb_word: valid %b word %b required 1/11001", word_valid, word_out); end
    word_ready = 1;
    cyc();
    word_ready = 0;
    n_cmp++;
    if (word_valid !== 1'b0) begin n_bad++; $display("FAIL lsb_release: valid %b required 0", word_valid); end
  endtask
  task automatic test_random();
    for (int n = 0; n < 25; n++) begin
      logic msb = 1'($urandom);
      logic [FRAME-1:0] f = seq(WIDTH'($urandom), 1'($urandom));
      send_frame(f, msb, 4);
      n_cmp++;
      if (word_valid !== 1'b1 || word_out !== model_word(f, msb) || parity_err !== model_par(f)) begin
        n_bad++;
        $display("FAIL rand_word[%0d]: valid %b word %b perr %b required 1/%b/%b", n, word_valid, word_out, parity_err, model_word(f, msb), model_par(f));
      end
      repeat ($urandom_range(0, 3)) cyc();
      n_cmp++;
      if (word_valid !== 1'b1 || word_out !== model_word(f, msb)) begin n_bad++; $display("FAIL rand_hold[%0d]: valid %b word %b required 1/%b", n, word_valid, word_out, model_word(f, msb)); end
      word_ready = 1;
      cyc();
      word_ready = 0;
      n_cmp++;
      if (word_valid !== 1'b0) begin n_bad++; $display("FAIL rand_release[%0d]: valid %b required 0", n, word_valid); end
    end
  endtask
  task automatic test_backpressure();
    logic [FRAME-1:0] f = seq(5'b10011, 1'b1);
    logic hold_ok = 1;
    send_frame(f, 1, 0);
    for (int k = 0; k < 4; k++) begin
      bit_valid = k == 1;
      bit_in = 1'($urandom);
      start = k == 2;
      cyc();
      hold_ok &= word_valid === 1'b1 && word_out === 5'b10011;
    end
    bit_valid = 0; start = 0;
    n_cmp++;
    if (hold_ok !== 1'b1) begin n_bad++; $display("FAIL bp_hold: word %b valid %b required 10011/1", word_out, word_valid); end
    n_cmp++;
    if (overrun !== 1'b1) begin n_bad++; $display("FAIL bp_overrun: got %b required 1", overrun); end
    word_ready = 1; start = 1;
    cyc();
    word_ready = 0; start = 0;
    n_cmp++;
    if (word_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b1) begin n_bad++; $display("FAIL bp_release: valid %b busy %b ovr %b required 0/0/1", word_valid, busy, overrun); end
    do_start(1);
    n_cmp++;
    if (overrun !== 1'b0) begin n_bad++; $display("FAIL bp_clear: got %b required 0", overrun); end
  endtask
  task automatic test_timeout();
    int pulses = 0;
    logic [FRAME-1:0] f;
    do_start(1);
    send(1, 0);
    send(0, 0);
    for (int k = 1; k <= TIMEOUT; k++) begin
      cyc();
      pulses += int'(timeout_err);
      if (k == TIMEOUT) begin
        n_cmp++;
        if (timeout_err !== 1'b1 || busy !== 1'b0 || word_valid !== 1'b0) begin n_bad++; $display("FAIL tmo_fire: tmo %b busy %b valid %b required 1/0/0", timeout_err, busy, word_valid); end
      end
    end
    cyc();
    n_cmp++;
    if (pulses !== 1 || timeout_err !== 1'b0) begin n_bad++; $display("FAIL tmo_pulse: pulses %0d tmo %b required 1/0", pulses, timeout_err); end
    do_start(1);
    repeat (3) send(1'($urandom), 0);
    start = 1; msb_first = 0; bit_valid = 1; bit_in = 1;
    cyc();
    start = 0; msb_first = 1; bit_valid = 0;
    n_cmp++;
    if (busy !== 1'b1 || word_out !== '0) begin n_bad++; $display("FAIL restart_clear: busy %b word %b required 1/00000", busy, word_out); end
    f = seq(WIDTH'($urandom), 1'b1);
    for (int i = 0; i < FRAME; i++) send(f[i], $urandom_range(0, 2));
    n_cmp++;
    if (word_valid !== 1'b1 || word_out !== model_word(f, 0)) begin n_bad++; $display("FAIL restart_word: valid %b word %b required 1/%b", word_valid, word_out, model_word(f, 0)); end
    word_ready = 1;
    cyc();
    word_ready = 0;
  endtask
  task automatic test_reset_mid();
    logic [FRAME-1:0] f = seq(5'b01101, 1'b1);
    do_start(1);
    repeat (3) send(1, 0);
    #2 rst_n = 0;
    #1;
    n_cmp++;
    if ({word_valid, busy, overrun, timeout_err, parity_err, word_out} !== '0) begin n_bad++; $display("FAIL rst_mid: got %b required 0", {word_valid, busy, overrun, timeout_err, parity_err, word_out}); end
    @(negedge clk) rst_n = 1;
    cyc();
    send_frame(f, 1, 1);
    n_cmp++;
    if (word_valid !== 1'b1 || word_out !== 5'b01101) begin n_bad++; $display("FAIL rst_after: valid %b word %b required 1/01101", word_valid, word_out); end
    #2 rst_n = 0;
    #1;
    n_cmp++;
    if (word_valid !== 1'b0 || word_out !== '0) begin n_bad++; $display("FAIL rst_hold: valid %b word %b required 0/00000", word_valid, word_out); end
    @(negedge clk) rst_n = 1;
    repeat (TIMEOUT + 2) cyc();
    n_cmp++;
    if (timeout_err !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL rst_quiet: tmo %b busy %b required 0/0", timeout_err, busy); end
  endtask
`ifdef PARITY_EN
  task automatic test_parity();
    for (int g = 1; g >= 0; g--) begin
      send_frame(seq(5'b10110, 1'(g)), 1, 1);
      n_cmp++;
      if (word_valid !== 1'b1 || word_out !== 5'b10110 || parity_err !== 1'(1 - g)) begin
        n_bad++;
        $display("FAIL parity[%0d]: valid %b word %b perr %b required 1/10110/%0d", g, word_valid, word_out, parity_err, 1 - g);
      end
      word_ready = 1;
      cyc();
      word_ready = 0;
    end
  endtask
`endif
  initial begin
    test_reset();
    test_msb_first();
    test_lsb_gaps();
    test_random();
    test_backpressure();
    test_timeout();
    test_reset_mid();
`ifdef PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
